// File: rtl/fetch_queue.sv
// Purpose: circular buffer of fetched {pc, inst} pairs between fetch and decode.
// Latency: one cycle from push to visibility on id_*; no fall-through path.
// Backpressure: if_ready drops only when full (state-only); id_valid drops when empty.
module fetch_queue #(
  parameter int ADDR_W    = 64,
  parameter int INST_W    = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic                       if_valid,
  output logic                       if_ready,
  output logic                       if_afull,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       id_stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  // Handshake qualifiers; if_ready never looks at id_ready, so a full queue cannot pop-through.
  always_comb begin
    if_ready     = (cnt != DEPTH_C);
    id_valid     = (cnt != '0);
    push         = if_valid && if_ready;
    pop          = id_valid && id_ready;
    if_afull     = (cnt >= AFULL_C);
    id_stall_req = !rst && (cnt == '0);
    count        = cnt;
  end

  // Pointer and occupancy state; flush beats any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Entry storage needs no reset; an empty queue masks whatever is held there.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
  end

  // Head presentation: zero bubble whenever nothing is valid.
  always_comb begin
    head    = mem[rd_ptr];
    id_pc   = '0;
    id_inst = '0;
    if (id_valid) begin
      id_pc   = head.pc;
      id_inst = head.inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose: directed self-checking bench for fetch_queue (DEPTH=4, AFULL_LVL=3).
// Latency: inputs applied after one edge, outputs compared 1 time unit after the next.
// Backpressure: exercises full, empty, flush and wrap boundaries.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_ready;
  logic        if_afull;
  logic        flush;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  count;
  logic        id_stall_req;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_queue #(.ADDR_W(64), .INST_W(32), .DEPTH(4), .AFULL_LVL(3)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_ready(if_ready),
    .if_afull(if_afull), .flush(flush),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_ready(id_ready),
    .count(count), .id_stall_req(id_stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        idr;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_vld;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_afull;
    logic        e_stall;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [63:0] pc,
                              input logic [31:0] inst, input logic idr, input logic [2:0] e_cnt,
                              input logic e_rdy, input logic e_vld, input logic [63:0] e_pc,
                              input logic [31:0] e_inst, input logic e_afull, input logic e_stall);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.idr = idr;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_afull = e_afull; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk($sformatf("%s.count", tag), 64'(count), 64'(v.e_cnt));
    chk($sformatf("%s.if_ready", tag), 64'(if_ready), 64'(v.e_rdy));
    chk($sformatf("%s.id_valid", tag), 64'(id_valid), 64'(v.e_vld));
    chk($sformatf("%s.id_pc", tag), id_pc, v.e_pc);
    chk($sformatf("%s.id_inst", tag), 64'(id_inst), 64'(v.e_inst));
    chk($sformatf("%s.if_afull", tag), 64'(if_afull), 64'(v.e_afull));
    chk($sformatf("%s.id_stall_req", tag), 64'(id_stall_req), 64'(v.e_stall));
  endtask

  task automatic apply(input string tag, input vec_t v);
    flush    = v.fl;
    if_valid = v.iv;
    if_pc    = v.pc;
    if_inst  = v.inst;
    id_ready = v.idr;
    @(posedge clk);
    #1;
    chk_all(tag, v);
  endtask

  initial begin
    // Fill, overfill, drain, empty race, simultaneous push/pop, flush with everything asserted.
    //               fl iv pc              inst          idr cnt rdy vld e_pc            e_inst        af st
    vecs[0]  = mk(0, 1, 64'h8000_0000, 32'h0000_0013, 0, 1, 1, 1, 64'h8000_0000, 32'h0000_0013, 0, 0);
    vecs[1]  = mk(0, 1, 64'h8000_0004, 32'h0010_0093, 0, 2, 1, 1, 64'h8000_0000, 32'h0000_0013, 0, 0);
    vecs[2]  = mk(0, 1, 64'h8000_0008, 32'h0020_0113, 0, 3, 1, 1, 64'h8000_0000, 32'h0000_0013, 1, 0);
    vecs[3]  = mk(0, 1, 64'h8000_000C, 32'h0030_0193, 0, 4, 0, 1, 64'h8000_0000, 32'h0000_0013, 1, 0);
    vecs[4]  = mk(0, 1, 64'h8000_0010, 32'hDEAD_BEEF, 0, 4, 0, 1, 64'h8000_0000, 32'h0000_0013, 1, 0);
    vecs[5]  = mk(0, 0, 64'h0,         32'h0,         1, 3, 1, 1, 64'h8000_0004, 32'h0010_0093, 1, 0);
    vecs[6]  = mk(0, 0, 64'h0,         32'h0,         1, 2, 1, 1, 64'h8000_0008, 32'h0020_0113, 0, 0);
    vecs[7]  = mk(0, 0, 64'h0,         32'h0,         1, 1, 1, 1, 64'h8000_000C, 32'h0030_0193, 0, 0);
    vecs[8]  = mk(0, 0, 64'h0,         32'h0,         1, 0, 1, 0, 64'h0,         32'h0,         0, 1);
    vecs[9]  = mk(0, 1, 64'h300,       32'h33,        1, 1, 1, 1, 64'h300,       32'h33,        0, 0);
    vecs[10] = mk(0, 1, 64'h304,       32'h34,        1, 1, 1, 1, 64'h304,       32'h34,        0, 0);
    vecs[11] = mk(0, 1, 64'h308,       32'h35,        0, 2, 1, 1, 64'h304,       32'h34,        0, 0);
    vecs[12] = mk(0, 1, 64'h30C,       32'h36,        0, 3, 1, 1, 64'h304,       32'h34,        1, 0);
    vecs[13] = mk(1, 1, 64'h200,       32'h99,        1, 0, 1, 0, 64'h0,         32'h0,         0, 1);
    vecs[14] = mk(0, 0, 64'h0,         32'h0,         1, 0, 1, 0, 64'h0,         32'h0,         0, 1);

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
    #2;
    // During reset: empty, ready, no stall request.
    chk_all("reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_reset.id_stall_req", 64'(id_stall_req), 64'h1);

    for (int i = 0; i < 15; i++) apply($sformatf("v%0d", i), vecs[i]);

    // Streaming across the pointer wrap: occupancy stays at one, PCs emerge in order.
    for (int k = 0; k < 10; k++) begin
      flush    = 1'b0;
      if_valid = 1'b1;
      if_pc    = 64'h100 + 64'(4 * k);
      if_inst  = 32'h1000 + 32'(k);
      id_ready = 1'b1;
      if (k == 0) begin
        #1;
        chk("stream.no_fall_through", 64'(id_valid), 64'h0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.id_valid", k), 64'(id_valid), 64'h1);
      chk($sformatf("stream%0d.id_pc", k), id_pc, 64'h100 + 64'(4 * k));
      chk($sformatf("stream%0d.id_inst", k), 64'(id_inst), 64'h1000 + 64'(k));
      chk($sformatf("stream%0d.count", k), 64'(count), 64'h1);
    end
    if_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_end.count", 64'(count), 64'h0);
    chk("stream_end.id_pc", id_pc, 64'h0);

    // Asynchronous reset with two entries held.
    apply("pre_rst0", mk(0, 1, 64'h400, 32'h41, 0, 1, 1, 1, 64'h400, 32'h41, 0, 0));
    apply("pre_rst1", mk(0, 1, 64'h404, 32'h42, 0, 2, 1, 1, 64'h400, 32'h41, 0, 0));
    if_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", mk(0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("after_rst.count", 64'(count), 64'h0);
    chk("after_rst.id_stall_req", 64'(id_stall_req), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
